// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: derives one-cycle increment enables for the cascaded
// mod-60 seconds/minutes counters and handles run/pause, clear and adjust mode.
//
// Ports:
//   clk, rst_n   system clock (posedge) and asynchronous active-low reset
//   pause_pls    debounced pulse, toggles run/pause
//   clear_pls    debounced pulse, clears counters and returns to idle
//   adj_mode     level, adjust mode requested
//   adj_sel      level, adjust field: 0 = minutes, 1 = seconds
//   sec_wrap     seconds counter 59->0 wrap flag
//   sec_inc      registered increment enable to the seconds counter
//   min_inc      registered increment enable to the minutes counter
//   cnt_clr      registered synchronous clear to both counters
//   running      registered, high while running
//   adjusting    registered, high while adjusting
//   blink        registered display blink phase, low outside adjust mode
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned ADJ_HZ   = 2,
  parameter int unsigned BLINK_HZ = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause_pls,
  input  logic clear_pls,
  input  logic adj_mode,
  input  logic adj_sel,
  input  logic sec_wrap,
  output logic sec_inc,
  output logic min_inc,
  output logic cnt_clr,
  output logic running,
  output logic adjusting,
  output logic blink
);

  localparam int unsigned ADJ_DIV = CLK_HZ / ADJ_HZ;
  localparam int unsigned BLK_DIV = CLK_HZ / BLINK_HZ;
  // Guard against a zero-width divider when a divisor collapses to 1.
  localparam int unsigned RUN_W = (CLK_HZ  > 1) ? $clog2(CLK_HZ)  : 1;
  localparam int unsigned ADJ_W = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
  localparam int unsigned BLK_W = (BLK_DIV > 1) ? $clog2(BLK_DIV) : 1;

  localparam logic [RUN_W-1:0] RUN_TC = RUN_W'(CLK_HZ - 1);
  localparam logic [ADJ_W-1:0] ADJ_TC = ADJ_W'(ADJ_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_TC = BLK_W'(BLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_ADJ   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [ADJ_W-1:0] adj_q, adj_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             blink_d, sec_d, min_d, clr_d;
  logic             run_tc, adj_tc, blk_tc;

  assign run_tc = (run_q == RUN_TC);
  assign adj_tc = (adj_q == ADJ_TC);
  assign blk_tc = (blk_q == BLK_TC);

  // State register, dividers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      run_q     <= '0;
      adj_q     <= '0;
      blk_q     <= '0;
      blink     <= 1'b0;
      sec_inc   <= 1'b0;
      min_inc   <= 1'b0;
      cnt_clr   <= 1'b0;
      running   <= 1'b0;
      adjusting <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      adj_q     <= adj_d;
      blk_q     <= blk_d;
      blink     <= blink_d;
      sec_inc   <= sec_d;
      min_inc   <= min_d;
      cnt_clr   <= clr_d;
      running   <= (state_d == S_RUN);
      adjusting <= (state_d == S_ADJ);
    end
  end

  // Next-state, divider and pulse logic; clear overrides everything,
  // including any tick or carry falling in the same cycle.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    adj_d   = adj_q;
    blk_d   = blk_q;
    blink_d = blink;
    sec_d   = 1'b0;
    min_d   = 1'b0;
    clr_d   = 1'b0;

    if (clear_pls) begin
      clr_d   = 1'b1;
      state_d = S_IDLE;
      run_d   = '0;
      adj_d   = '0;
      blk_d   = '0;
      blink_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          run_d = '0;
          if (adj_mode)       state_d = S_ADJ;
          else if (pause_pls) state_d = S_RUN;
        end
        S_RUN: begin
          run_d = run_tc ? '0 : run_q + RUN_W'(1);
          sec_d = run_tc;
          min_d = sec_wrap;
          if (pause_pls) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (adj_mode)       state_d = S_ADJ;
          else if (pause_pls) state_d = S_RUN;
        end
        S_ADJ: begin
          adj_d = adj_tc ? '0 : adj_q + ADJ_W'(1);
          blk_d = blk_tc ? '0 : blk_q + BLK_W'(1);
          if (blk_tc) blink_d = ~blink;
          if (adj_sel) sec_d = adj_tc;
          else         min_d = adj_tc;
          // Leaving adjust restarts the adjust/blink phase for next time.
          if (!adj_mode) begin
            state_d = S_PAUSE;
            adj_d   = '0;
            blk_d   = '0;
            blink_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios followed by random stimulus,
// all compared every cycle against a behavioural model of the stopwatch.
module tb_stopwatch_ctrl;

  localparam int unsigned CLK_HZ   = 8;
  localparam int unsigned ADJ_HZ   = 2;
  localparam int unsigned BLINK_HZ = 4;
  localparam int unsigned ADJ_N    = CLK_HZ / ADJ_HZ;
  localparam int unsigned BLK_N    = CLK_HZ / BLINK_HZ;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pause_pls = 1'b0, clear_pls = 1'b0, adj_mode = 1'b0, adj_sel = 1'b0, sec_wrap = 1'b0;
  logic sec_inc, min_inc, cnt_clr, running, adjusting, blink;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .ADJ_HZ(ADJ_HZ), .BLINK_HZ(BLINK_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .pause_pls(pause_pls), .clear_pls(clear_pls),
    .adj_mode(adj_mode), .adj_sel(adj_sel), .sec_wrap(sec_wrap),
    .sec_inc(sec_inc), .min_inc(min_inc), .cnt_clr(cnt_clr),
    .running(running), .adjusting(adjusting), .blink(blink)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model: stopwatch mode plus elapsed-cycle phases.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_ADJ} mode_t;
  mode_t mode;
  int    run_ph, adj_ph, blk_ph;
  bit    m_blink, m_sec, m_min, m_clr;

  function automatic void model_reset();
    mode = M_IDLE; run_ph = 0; adj_ph = 0; blk_ph = 0;
    m_blink = 0; m_sec = 0; m_min = 0; m_clr = 0;
  endfunction

  function automatic void model_step(input bit p, input bit c, input bit a,
                                     input bit s, input bit w);
    m_sec = 0; m_min = 0; m_clr = 0;
    if (c) begin
      m_clr = 1; mode = M_IDLE; run_ph = 0; adj_ph = 0; blk_ph = 0; m_blink = 0;
    end else if (mode == M_IDLE) begin
      if (a) mode = M_ADJ; else if (p) mode = M_RUN;
    end else if (mode == M_RUN) begin
      run_ph = (run_ph + 1) % CLK_HZ;
      m_sec = (run_ph == 0);
      m_min = w;
      if (p) mode = M_PAUSE;
    end else if (mode == M_PAUSE) begin
      if (a) mode = M_ADJ; else if (p) mode = M_RUN;
    end else begin
      adj_ph = (adj_ph + 1) % ADJ_N;
      blk_ph = (blk_ph + 1) % BLK_N;
      if (blk_ph == 0) m_blink = !m_blink;
      if (adj_ph == 0) begin
        if (s) m_sec = 1; else m_min = 1;
      end
      if (!a) begin
        mode = M_PAUSE; adj_ph = 0; blk_ph = 0; m_blink = 0;
      end
    end
  endfunction

  function automatic logic [5:0] model_vec();
    return {m_sec, m_min, m_clr, mode == M_RUN, mode == M_ADJ, m_blink};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check(tag, 32'({sec_inc, min_inc, cnt_clr, running, adjusting, blink}), 32'(model_vec()));
  endtask

  // One clock: drive pulses and levels, advance the model, compare after the edge.
  task automatic step(input bit p, input bit c, input bit w);
    pause_pls = p; clear_pls = c; sec_wrap = w;
    @(posedge clk);
    model_step(p, c, adj_mode, adj_sel, w);
    #1;
    check_all("cycle");
    pause_pls = 0; clear_pls = 0; sec_wrap = 0;
  endtask

  // Idle cycles until sec_inc is observed; n = cycles taken (bounded).
  task automatic wait_sec(input int limit, output int n);
    n = 0;
    do begin
      step(0, 0, 0);
      n++;
    end while (!sec_inc && n < limit);
    if (!sec_inc) n = -1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    check("reset_async", 32'({sec_inc, min_inc, cnt_clr, running, adjusting, blink}), 32'd0);
    @(posedge clk); #1;
    check_all("reset_held");
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  int n;
  int seen_min;

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // 1. start running; ticks every CLK_HZ cycles, first one CLK_HZ after entry
    step(1, 0, 0);
    check("t1_running", 32'(running), 32'd1);
    wait_sec(20, n);
    check("t1_first_tick", 32'(n), 32'(CLK_HZ));
    wait_sec(20, n);
    check("t1_period", 32'(n), 32'(CLK_HZ));
    check("t1_no_clr", 32'(cnt_clr), 32'd0);

    // 2. pause three cycles after a tick; phase is preserved across the pause
    step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0);
    check("t2_paused", 32'(running), 32'd0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    step(1, 0, 0);
    wait_sec(20, n);
    check("t2_resume_tick", 32'(n), 32'd5);

    // 3. carry only in RUN
    step(0, 0, 1);
    check("t3_carry", 32'(min_inc), 32'd1);
    step(0, 0, 0);
    check("t3_carry_one_cycle", 32'(min_inc), 32'd0);
    step(1, 0, 0);
    step(0, 0, 1);
    check("t3_no_carry_paused", 32'(min_inc), 32'd0);

    // 4. adjust seconds from PAUSE; carry ignored, blink runs then clears
    adj_sel = 1; adj_mode = 1;
    step(0, 0, 0);
    check("t4_adjusting", 32'(adjusting), 32'd1);
    wait_sec(20, n);
    check("t4_adj_tick", 32'(n), 32'(ADJ_N));
    seen_min = 0;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 1);
      if (min_inc) seen_min++;
    end
    check("t4_no_min", 32'(seen_min), 32'd0);
    adj_mode = 0;
    step(0, 0, 0);
    check("t4_exit_blink", 32'(blink), 32'd0);
    check("t4_exit_adj", 32'(adjusting), 32'd0);

    // 5. clear beats pause in RUN; restart takes a full period
    step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0);
    step(1, 1, 0);
    check("t5_clr", 32'(cnt_clr), 32'd1);
    check("t5_idle", 32'(running), 32'd0);
    step(0, 0, 0);
    check("t5_clr_one_cycle", 32'(cnt_clr), 32'd0);
    step(1, 0, 0);
    wait_sec(20, n);
    check("t5_restart_tick", 32'(n), 32'(CLK_HZ));

    // 6. reset one cycle before a due tick aborts it
    for (int i = 0; i < int'(CLK_HZ) - 1; i++) step(0, 0, 0);
    @(negedge clk);
    do_reset();
    check("t6_no_tick", 32'(sec_inc), 32'd0);
    step(0, 0, 0);
    check("t6_idle", 32'(running), 32'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) adj_mode = !adj_mode;
      if ($urandom_range(0, 19) == 0) adj_sel = !adj_sel;
      if ($urandom_range(0, 699) == 0) begin
        @(negedge clk);
        do_reset();
      end
      step($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
